// File: rtl/sccb_wr_master.sv
// SCCB write engine: one 4-byte write {dev_wr, addr_hi, addr_lo, value} per cfg_start,
// with quarter-period timebase, registered push-pull SCL and open-drain style SDA enable.
module sccb_wr_master #(
  parameter int         SYS_CLK_FREQ = 50_000_000,
  parameter int         SCL_FREQ     = 250_000,
  parameter logic [6:0] DEVICE_ADDR  = 7'h3C,
  parameter int         QTR_CNT      = SYS_CLK_FREQ / (SCL_FREQ * 4)
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        cfg_start,
  input  logic [23:0] cfg_data,
  output logic        cfg_end,
  output logic        busy,
  output logic        ack_err,
  output logic        scl,
  output logic        sda_oe,
  input  logic        sda_in
);

  localparam int QW = (QTR_CNT > 1) ? $clog2(QTR_CNT) : 1;

  typedef enum logic [2:0] {IDLE, START, BYTE, ACK, STOP, DONE} state_t;

  state_t        state;
  logic [QW-1:0] qcnt;
  logic [1:0]    qtr;
  logic [2:0]    bit_cnt;
  logic [1:0]    byte_cnt;
  logic [31:0]   shreg;
  logic          tick;

  assign tick = busy && (qcnt == QW'(QTR_CNT - 1));

  // Bus outputs are updated at each quarter tick with the values of the quarter being entered.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= IDLE;
      qcnt     <= '0;
      qtr      <= 2'd0;
      bit_cnt  <= 3'd0;
      byte_cnt <= 2'd0;
      shreg    <= '0;
      scl      <= 1'b1;
      sda_oe   <= 1'b0;
      cfg_end  <= 1'b0;
      busy     <= 1'b0;
      ack_err  <= 1'b0;
    end else begin
      cfg_end <= 1'b0;
      if (busy) qcnt <= tick ? '0 : qcnt + QW'(1);
      case (state)
        IDLE: begin
          if (cfg_start) begin
            shreg   <= {DEVICE_ADDR, 1'b0, cfg_data};
            ack_err <= 1'b0;
            busy    <= 1'b1;
            qcnt    <= '0;
            qtr     <= 2'd0;
            scl     <= 1'b1;
            sda_oe  <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (tick) begin
            qtr <= qtr + 2'd1;
            case (qtr)
              2'd0: sda_oe <= 1'b1;
              2'd1: ;
              2'd2: scl <= 1'b0;
              2'd3: begin
                state    <= BYTE;
                bit_cnt  <= 3'd7;
                byte_cnt <= 2'd0;
                sda_oe   <= ~shreg[31];
              end
            endcase
          end
        end
        BYTE: begin
          if (tick) begin
            qtr <= qtr + 2'd1;
            case (qtr)
              2'd0: scl <= 1'b1;
              2'd1: ;
              2'd2: scl <= 1'b0;
              2'd3: begin
                // Shift every bit so shreg[31] is always the next bit to send.
                shreg   <= {shreg[30:0], 1'b0};
                bit_cnt <= bit_cnt - 3'd1;
                if (bit_cnt == 3'd0) begin
                  state  <= ACK;
                  sda_oe <= 1'b0;
                end else begin
                  sda_oe <= ~shreg[30];
                end
              end
            endcase
          end
        end
        ACK: begin
          if (tick) begin
            qtr <= qtr + 2'd1;
            case (qtr)
              2'd0: scl <= 1'b1;
              2'd1: ;
              2'd2: begin
                scl <= 1'b0;
                if (sda_in) ack_err <= 1'b1;
              end
              2'd3: begin
                if (ack_err || byte_cnt == 2'd3) begin
                  state  <= STOP;
                  sda_oe <= 1'b1;
                end else begin
                  state    <= BYTE;
                  byte_cnt <= byte_cnt + 2'd1;
                  bit_cnt  <= 3'd7;
                  sda_oe   <= ~shreg[31];
                end
              end
            endcase
          end
        end
        STOP: begin
          if (tick) begin
            qtr <= qtr + 2'd1;
            case (qtr)
              2'd0: scl <= 1'b1;
              2'd1: sda_oe <= 1'b0;
              2'd2: ;
              2'd3: begin
                state   <= DONE;
                busy    <= 1'b0;
                cfg_end <= 1'b1;
              end
            endcase
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_wr_master.sv
// Directed bench for sccb_wr_master: bus monitor/slave model decodes SDA on SCL rises
// and checks bytes, START/STOP, latency, NACK, ignored starts, reset and timebase.
module tb_sccb_wr_master;

  localparam int Q1   = 50;
  localparam int FULL = 152 * Q1;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic [23:0] cfg_data = 24'h0;
  logic        cfg_end, busy, ack_err, scl, sda_oe, sda_in;

  logic        cfg_start2 = 1'b0;
  logic [23:0] cfg_data2 = 24'h0;
  logic        cfg_end2, busy2, ack_err2, scl2, sda_oe2, sda_in2;

  always #5 sys_clk = ~sys_clk;

  sccb_wr_master dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_start(cfg_start), .cfg_data(cfg_data),
    .cfg_end(cfg_end), .busy(busy), .ack_err(ack_err), .scl(scl), .sda_oe(sda_oe),
    .sda_in(sda_in)
  );

  sccb_wr_master #(.SYS_CLK_FREQ(100_000_000), .SCL_FREQ(250_000)) dut2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_start(cfg_start2), .cfg_data(cfg_data2),
    .cfg_end(cfg_end2), .busy(busy2), .ack_err(ack_err2), .scl(scl2), .sda_oe(sda_oe2),
    .sda_in(sda_in2)
  );

  // No slave on the second instance: pull-up makes every ACK slot a NACK.
  assign sda_in2 = ~sda_oe2;

  // Bus monitor and slave for the main instance.
  int         nack_byte = 99;
  logic       p_scl = 1'b1, p_sda = 1'b1;
  int         m_bits = 0, m_byte = 0;
  logic       m_ack = 1'b0;
  logic [7:0] m_sh = 8'h0;
  logic [7:0] bytes_q[$];
  int         n_start = 0, n_stop = 0;
  logic       slave_low, sda_bus;

  assign slave_low = m_ack && (m_byte != nack_byte);
  assign sda_bus   = ~sda_oe & ~slave_low;
  assign sda_in    = sda_bus;

  always @(posedge sys_clk) begin
    if (sys_rst) begin
      m_bits <= 0;
      m_byte <= 0;
      m_ack  <= 1'b0;
      p_scl  <= scl;
      p_sda  <= sda_bus;
    end else begin
      if (p_scl && scl && p_sda && !sda_bus) begin
        n_start <= n_start + 1;
        m_bits  <= 0;
        m_byte  <= 0;
        m_ack   <= 1'b0;
        bytes_q.delete();
      end
      if (p_scl && scl && !p_sda && sda_bus) n_stop <= n_stop + 1;
      if (!p_scl && scl && m_bits < 8) begin
        m_sh   <= {m_sh[6:0], sda_bus};
        m_bits <= m_bits + 1;
        if (m_bits == 7) bytes_q.push_back({m_sh[6:0], sda_bus});
      end
      if (p_scl && !scl) begin
        if (m_bits == 8 && !m_ack) m_ack <= 1'b1;
        else if (m_ack) begin
          m_ack  <= 1'b0;
          m_bits <= 0;
          m_byte <= m_byte + 1;
        end
      end
      p_scl <= scl;
      p_sda <= sda_bus;
    end
  end

  int n_chk = 0, n_fail = 0;
  int end_k, busy_n, s0, e0, xend;
  int r1, r2, f1, e2;
  logic ps;
  logic [23:0] b2b [3] = '{24'h310311, 24'h300882, 24'h300842};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bytes(input string tag, input logic [23:0] d, input int n);
    logic [31:0] w;
    logic [31:0] obs;
    w = {8'h78, d};
    chk({tag, "_nbytes"}, bytes_q.size(), n);
    for (int i = 0; i < n; i++) begin
      obs = (i < bytes_q.size()) ? {24'h0, bytes_q[i]} : 32'hdead;
      chk($sformatf("%s_byte%0d", tag, i), obs, {24'h0, w[31-8*i -: 8]});
    end
  endtask

  // Pulses cfg_start, optionally re-pulses it mid-transaction (gk), scrambles cfg_data
  // while busy, and waits (bounded) for cfg_end.
  task automatic do_write(input string tag, input logic [23:0] d, input int nb, input int gk);
    nack_byte = nb;
    s0 = n_start;
    e0 = n_stop;
    @(negedge sys_clk);
    cfg_data  = d;
    cfg_start = 1'b1;
    end_k  = 0;
    busy_n = 0;
    for (int k = 1; k <= 20000; k++) begin
      @(negedge sys_clk);
      cfg_start = (k == gk);
      if (k == 1) begin
        cfg_data = ~d;
        chk({tag, "_ackerr_clr"}, ack_err, 0);
      end
      if (busy) busy_n++;
      if (cfg_end) begin
        end_k = k;
        break;
      end
    end
    chk({tag, "_done_seen"}, end_k != 0, 1);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge sys_clk);
    chk("rst_scl", scl, 1);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_end", cfg_end, 0);
    chk("rst_ack_err", ack_err, 0);
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    // Single acknowledged write
    do_write("single", 24'h310311, 99, 0);
    chk("single_lat", end_k, FULL + 1);
    chk("single_busy", busy_n, FULL);
    chk("single_ack_err", ack_err, 0);
    chk("single_nstart", n_start - s0, 1);
    chk("single_nstop", n_stop - e0, 1);
    chk_bytes("single", 24'h310311, 4);

    // NACK on byte 1
    do_write("nack", 24'h300882, 1, 0);
    chk("nack_lat", end_k, 80 * Q1 + 1);
    chk("nack_busy", busy_n, 80 * Q1);
    chk("nack_ack_err", ack_err, 1);
    chk("nack_nstop", n_stop - e0, 1);
    chk_bytes("nack", 24'h300882, 2);

    // Back-to-back; the first of these also shows ack_err cleared by a new start
    for (int i = 0; i < 3; i++) begin
      do_write($sformatf("b2b%0d", i), b2b[i], 99, 0);
      chk($sformatf("b2b%0d_lat", i), end_k, FULL + 1);
      chk($sformatf("b2b%0d_busy", i), busy_n, FULL);
      chk($sformatf("b2b%0d_nstart", i), n_start - s0, 1);
      chk_bytes($sformatf("b2b%0d", i), b2b[i], 4);
    end

    // cfg_start pulsed mid-transaction with other data
    do_write("glitch", 24'h3a1855, 99, 2000);
    chk("glitch_lat", end_k, FULL + 1);
    chk_bytes("glitch", 24'h3a1855, 4);
    xend = 0;
    repeat (300) begin
      @(negedge sys_clk);
      if (cfg_end) xend++;
    end
    chk("glitch_extra_end", xend, 0);
    chk("glitch_idle", busy, 0);

    // Reset in the middle of byte 2
    nack_byte = 99;
    e0 = n_stop;
    @(negedge sys_clk);
    cfg_data  = 24'h3a0c55;
    cfg_start = 1'b1;
    @(negedge sys_clk);
    cfg_start = 1'b0;
    repeat (4500) @(negedge sys_clk);
    chk("midrst_in_byte2", bytes_q.size(), 2);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("midrst_scl", scl, 1);
    chk("midrst_sda_oe", sda_oe, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cfg_end", cfg_end, 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (20) @(negedge sys_clk);
    chk("midrst_no_stop", n_stop - e0, 0);
    chk("midrst_still_idle", busy, 0);

    // Clean transaction after the reset
    do_write("post", 24'h4300aa, 99, 0);
    chk("post_lat", end_k, FULL + 1);
    chk("post_nstart", n_start - s0, 1);
    chk("post_nstop", n_stop - e0, 1);
    chk_bytes("post", 24'h4300aa, 4);

    // 100 MHz instance: QTR_CNT = 100, SCL period 400 cycles, NACK on byte 0
    r1 = 0; r2 = 0; f1 = 0; e2 = 0; ps = 1'b1;
    @(negedge sys_clk);
    cfg_data2  = 24'h310311;
    cfg_start2 = 1'b1;
    for (int k = 1; k <= 20000; k++) begin
      @(negedge sys_clk);
      cfg_start2 = 1'b0;
      if (!ps && scl2) begin
        if (r1 == 0) r1 = k;
        else if (r2 == 0) r2 = k;
      end
      if (ps && !scl2 && r1 != 0 && f1 == 0) f1 = k;
      ps = scl2;
      if (cfg_end2) begin
        e2 = k;
        break;
      end
    end
    chk("p100_period", r2 - r1, 400);
    chk("p100_high", f1 - r1, 200);
    chk("p100_lat", e2, 44 * 100 + 1);
    chk("p100_ack_err", ack_err2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
